seq_divider: RTL

Iterative radix-2 restoring unsigned divider, the inverse counterpart of the team's adder family. It accepts an operand pair over a valid/ready handshake and performs one subtract-and-shift step per clock using an N+1-bit subtractor (adder with inverted divisor, carry-in 1). It returns quotient and remainder over a second valid/ready handshake. It sits beside the adder blocks as the first multi-cycle arithmetic unit and is checked against a software reference model.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 34 +++
 rtl/seq_divider.sv | 95 +++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  localparam int DIV_N = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divState_t;

  function automatic int cntWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring step: shift in the next dividend bit, trial-subtract D.
module div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rIn,
  input  logic [N-1:0] qIn,
  input  logic [N-1:0] dIn,
  output logic [N-1:0] rOut,
  output logic [N-1:0] qOut
);

  logic [N:0] rShift;
  logic [N:0] dInv;
  logic [N:0] diff;

  // The remainder is always below D, so the stored R never needs its top bit;
  // the full N+1-bit R' is formed here from rIn and the outgoing quotient bit.
  assign rShift = {rIn, qIn[N-1]};
  assign dInv   = ~{1'b0, dIn};

  always_comb begin
    logic c;
    diff = '0;
    c    = 1'b1;
    for (int unsigned i = 0; i <= N; i++) begin
      diff[i] = rShift[i] ^ dInv[i] ^ c;
      c       = (rShift[i] & dInv[i]) | (c & (rShift[i] ^ dInv[i]));
    end
  end

  assign rOut = diff[N] ? rShift[N-1:0] : diff[N-1:0];
  assign qOut = {qIn[N-2:0], ~diff[N]};

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring unsigned divider with valid/ready on both sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cntWidth(N);

  divState_t   state;
  logic [N-1:0] qReg;
  logic [N-1:0] rReg;
  logic [N-1:0] dReg;
  logic [CW-1:0] cnt;
  logic         dbzReg;
  logic         outValidReg;
  logic [N-1:0] rNext;
  logic [N-1:0] qNext;

  div_step #(.N(N)) uStep (
    .rIn  (rReg),
    .qIn  (qReg),
    .dIn  (dReg),
    .rOut (rNext),
    .qOut (qNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      qReg        <= '0;
      rReg        <= '0;
      dReg        <= '0;
      cnt         <= '0;
      dbzReg      <= 1'b0;
      outValidReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor != '0) begin
              qReg  <= dividend;
              rReg  <= '0;
              dReg  <= divisor;
              cnt   <= '0;
              state <= RUN;
            end else begin
              qReg        <= '1;
              rReg        <= dividend;
              dbzReg      <= 1'b1;
              outValidReg <= 1'b1;
              state       <= DONE;
            end
          end
        end
        RUN: begin
          qReg <= qNext;
          rReg <= rNext;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            outValidReg <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValidReg <= 1'b0;
            dbzReg      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = outValidReg;
  assign quotient    = qReg;
  assign remainder   = rReg;
  assign div_by_zero = dbzReg;

endmodule
